// File: rtl/dmem_lsu_bridge.sv
// Load/store bridge between the core MEM stage and the single-port ram2 data RAM.
// Runs one transaction at a time: address decode at accept, RAM access, lane extract, response.
module dmem_lsu_bridge #(
    parameter int          ADDR_WIDTH = 13,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [31:0]           req_addr,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [31:0]           req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [31:0]           rsp_rdata,
    output logic                  rsp_err,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [31:0]           ram_wr_data,
    output logic [3:0]            ram_wr_byte_en,
    output logic                  ram_wr_en,
    input  logic [31:0]           ram_rd_data
);

    // Handshakes: a request transfers on the edge where req_valid && req_ready; a response
    // transfers on the edge where rsp_valid && rsp_ready. rsp_* hold steady until then.
    typedef enum logic [1:0] {IDLE, ACCESS, RD_DATA, RESP} state_t;

    state_t      state, state_nxt;
    logic        accept, misalign, out_of_window, legal;
    logic [3:0]  be_nxt;
    logic [31:0] wdata_nxt;
    logic [1:0]  a_q, size_q;
    logic        uns_q, we_q;
    logic [7:0]  lane_b;
    logic [15:0] lane_h;
    logic [31:0] load_data;

    assign req_ready     = (state == IDLE);
    assign accept        = req_valid && req_ready;
    assign out_of_window = (req_addr[31:ADDR_WIDTH+2] != BASE_ADDR[31:ADDR_WIDTH+2]);
    assign legal         = !misalign && !out_of_window;

    always_comb begin
        misalign  = 1'b0;
        be_nxt    = 4'b0000;
        wdata_nxt = req_wdata;
        case (req_size)
            2'b00: begin
                be_nxt    = 4'b0001 << req_addr[1:0];
                wdata_nxt = {4{req_wdata[7:0]}};
            end
            2'b01: begin
                misalign  = req_addr[0];
                be_nxt    = req_addr[1] ? 4'b1100 : 4'b0011;
                wdata_nxt = {2{req_wdata[15:0]}};
            end
            2'b10: begin
                misalign = (req_addr[1:0] != 2'b00);
                be_nxt   = 4'b1111;
            end
            default: misalign = 1'b1;
        endcase
        if (!req_we) be_nxt = 4'b0000;
    end

    // Lane select uses the byte offset captured at accept; RAM data is valid during RD_DATA.
    always_comb begin
        lane_b = ram_rd_data[{a_q, 3'b000} +: 8];
        lane_h = a_q[1] ? ram_rd_data[31:16] : ram_rd_data[15:0];
        case (size_q)
            2'b00:   load_data = uns_q ? {24'b0, lane_b} : {{24{lane_b[7]}}, lane_b};
            2'b01:   load_data = uns_q ? {16'b0, lane_h} : {{16{lane_h[15]}}, lane_h};
            default: load_data = ram_rd_data;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = legal ? ACCESS : RESP;
            ACCESS:  state_nxt = we_q ? RESP : RD_DATA;
            RD_DATA: state_nxt = RESP;
            RESP:    if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ram_addr       <= '0;
            ram_wr_data    <= '0;
            ram_wr_byte_en <= '0;
            ram_wr_en      <= 1'b0;
            rsp_valid      <= 1'b0;
            rsp_rdata      <= '0;
            rsp_err        <= 1'b0;
            a_q            <= '0;
            size_q         <= '0;
            uns_q          <= 1'b0;
            we_q           <= 1'b0;
        end else begin
            ram_wr_en <= 1'b0;
            if (accept) begin
                a_q    <= req_addr[1:0];
                size_q <= req_size;
                uns_q  <= req_unsigned;
                we_q   <= req_we;
            end
            // Rejected requests never touch the RAM-side registers.
            if (accept && legal) begin
                ram_addr       <= req_addr[ADDR_WIDTH+1:2];
                ram_wr_data    <= wdata_nxt;
                ram_wr_byte_en <= be_nxt;
                ram_wr_en      <= req_we;
            end
            case (state)
                IDLE: if (accept && !legal) begin
                    rsp_valid <= 1'b1;
                    rsp_err   <= 1'b1;
                    rsp_rdata <= '0;
                end
                ACCESS: if (we_q) begin
                    rsp_valid <= 1'b1;
                    rsp_err   <= 1'b0;
                    rsp_rdata <= '0;
                end
                RD_DATA: begin
                    rsp_valid <= 1'b1;
                    rsp_err   <= 1'b0;
                    rsp_rdata <= load_data;
                end
                RESP: if (rsp_ready) rsp_valid <= 1'b0;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_lsu_bridge.sv
// Bench for dmem_lsu_bridge: behavioural ram2 model, vector table of requests with
// hand-computed results, and directed sequences for response backpressure and mid-store reset.
module tb_dmem_lsu_bridge;

    localparam int AW = 13;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req_valid, req_ready, req_we, req_unsigned;
    logic [31:0]   req_addr, req_wdata;
    logic [1:0]    req_size;
    logic          rsp_valid, rsp_ready, rsp_err;
    logic [31:0]   rsp_rdata;
    logic [AW-1:0] ram_addr;
    logic [31:0]   ram_wr_data, ram_rd_data;
    logic [3:0]    ram_wr_byte_en;
    logic          ram_wr_en;

    int checks   = 0;
    int failures = 0;
    logic [31:0] exp_q[$];

    dmem_lsu_bridge #(.ADDR_WIDTH(AW), .BASE_ADDR(32'h0)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_size(req_size), .req_unsigned(req_unsigned),
        .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err),
        .ram_addr(ram_addr), .ram_wr_data(ram_wr_data), .ram_wr_byte_en(ram_wr_byte_en),
        .ram_wr_en(ram_wr_en), .ram_rd_data(ram_rd_data)
    );

    // clock / ram2 model (1-cycle read latency, byte enables, cleared on the first edge)
    always #5 clk = ~clk;

    logic [31:0] mem [0:(1<<AW)-1];
    bit          mem_cleared = 1'b0;
    always @(posedge clk) begin
        if (!mem_cleared) begin
            for (int i = 0; i < (1 << AW); i++) mem[i] <= '0;
            mem_cleared <= 1'b1;
        end else if (ram_wr_en) begin
            for (int b = 0; b < 4; b++)
                if (ram_wr_byte_en[b]) mem[ram_addr][8*b +: 8] <= ram_wr_data[8*b +: 8];
        end
        ram_rd_data <= mem[ram_addr];
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic          we;
        logic [31:0]   addr;
        logic [1:0]    size;
        logic          uns;
        logic [31:0]   wdata;
        logic [31:0]   exp_rdata;
        logic          exp_err;
        int            exp_lat;
        int            exp_pulses;
        logic [3:0]    exp_be;
        logic [31:0]   exp_wd;
        logic [AW-1:0] exp_ra;
    } vec_t;

    // driver: one request, returns observed response, latency and RAM write activity
    task automatic do_req(input vec_t v, output logic [31:0] rd, output logic er,
                          output int lat, output int pulses, output logic [3:0] be,
                          output logic [31:0] wd, output logic [AW-1:0] ra);
        int n;
        rd = '0; er = 1'b0; lat = 0; pulses = 0; be = '0; wd = '0; ra = '0;
        @(negedge clk);
        req_valid = 1'b1; req_we = v.we; req_addr = v.addr; req_size = v.size;
        req_unsigned = v.uns; req_wdata = v.wdata;
        n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1 req_valid = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (k == 1) ra = ram_addr;
            if (ram_wr_en) begin
                pulses++;
                be = ram_wr_byte_en;
                wd = ram_wr_data;
            end
            if (rsp_valid) begin
                lat = k;
                break;
            end
        end
        rd = rsp_rdata;
        er = rsp_err;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
    endtask

    vec_t vecs [20];

    function automatic vec_t mk(input logic we, input logic [31:0] addr, input logic [1:0] size,
                                input logic uns, input logic [31:0] wdata,
                                input logic [31:0] exp_rdata, input logic exp_err,
                                input int exp_lat, input int exp_pulses, input logic [3:0] exp_be,
                                input logic [31:0] exp_wd, input logic [AW-1:0] exp_ra);
        vec_t v;
        v.we = we; v.addr = addr; v.size = size; v.uns = uns; v.wdata = wdata;
        v.exp_rdata = exp_rdata; v.exp_err = exp_err; v.exp_lat = exp_lat;
        v.exp_pulses = exp_pulses; v.exp_be = exp_be; v.exp_wd = exp_wd; v.exp_ra = exp_ra;
        return v;
    endfunction

    initial begin
        logic [31:0]   rd, exp_rd;
        logic          er;
        int            lat, pulses;
        logic [3:0]    be;
        logic [31:0]   wd;
        logic [AW-1:0] ra;
        string         tag;

        //              we    addr          sz    uns   wdata          rdata         err  lat p  be       wd             ra
        vecs[0]  = mk(1'b1, 32'h0000_0010, 2'b10, 1'b0, 32'hDEAD_BEEF, 32'h0,        1'b0, 2, 1, 4'b1111, 32'hDEAD_BEEF, 13'd4);
        vecs[1]  = mk(1'b0, 32'h0000_0010, 2'b10, 1'b0, 32'h0,         32'hDEAD_BEEF, 1'b0, 3, 0, 4'b0,    32'h0,         13'd4);
        vecs[2]  = mk(1'b0, 32'h0000_0013, 2'b00, 1'b0, 32'h0,         32'hFFFF_FFDE, 1'b0, 3, 0, 4'b0,    32'h0,         13'd4);
        vecs[3]  = mk(1'b0, 32'h0000_0012, 2'b00, 1'b1, 32'h0,         32'h0000_00AD, 1'b0, 3, 0, 4'b0,    32'h0,         13'd4);
        vecs[4]  = mk(1'b0, 32'h0000_0012, 2'b01, 1'b0, 32'h0,         32'hFFFF_DEAD, 1'b0, 3, 0, 4'b0,    32'h0,         13'd4);
        vecs[5]  = mk(1'b0, 32'h0000_0010, 2'b01, 1'b1, 32'h0,         32'h0000_BEEF, 1'b0, 3, 0, 4'b0,    32'h0,         13'd4);
        vecs[6]  = mk(1'b0, 32'h0000_0013, 2'b00, 1'b1, 32'h0,         32'h0000_00DE, 1'b0, 3, 0, 4'b0,    32'h0,         13'd4);
        vecs[7]  = mk(1'b1, 32'h0000_0021, 2'b00, 1'b0, 32'hFFFF_FF5A, 32'h0,        1'b0, 2, 1, 4'b0010, 32'h5A5A_5A5A, 13'd8);
        vecs[8]  = mk(1'b1, 32'h0000_0022, 2'b01, 1'b0, 32'hABCD_1234, 32'h0,        1'b0, 2, 1, 4'b1100, 32'h1234_1234, 13'd8);
        vecs[9]  = mk(1'b0, 32'h0000_0020, 2'b10, 1'b0, 32'h0,         32'h1234_5A00, 1'b0, 3, 0, 4'b0,    32'h0,         13'd8);
        vecs[10] = mk(1'b0, 32'h0000_0021, 2'b00, 1'b0, 32'h0,         32'h0000_005A, 1'b0, 3, 0, 4'b0,    32'h0,         13'd8);
        vecs[11] = mk(1'b0, 32'h0000_0020, 2'b01, 1'b0, 32'h0,         32'h0000_5A00, 1'b0, 3, 0, 4'b0,    32'h0,         13'd8);
        vecs[12] = mk(1'b1, 32'h0000_0011, 2'b01, 1'b0, 32'hFFFF_FFFF, 32'h0,        1'b1, 1, 0, 4'b0,    32'h0,         13'd0);
        vecs[13] = mk(1'b1, 32'h0000_0012, 2'b10, 1'b0, 32'hFFFF_FFFF, 32'h0,        1'b1, 1, 0, 4'b0,    32'h0,         13'd0);
        vecs[14] = mk(1'b1, 32'h0000_0010, 2'b11, 1'b0, 32'hFFFF_FFFF, 32'h0,        1'b1, 1, 0, 4'b0,    32'h0,         13'd0);
        vecs[15] = mk(1'b1, 32'h0000_8000, 2'b10, 1'b0, 32'h7777_7777, 32'h0,        1'b1, 1, 0, 4'b0,    32'h0,         13'd0);
        vecs[16] = mk(1'b0, 32'h0000_8010, 2'b10, 1'b0, 32'h0,         32'h0,        1'b1, 1, 0, 4'b0,    32'h0,         13'd0);
        vecs[17] = mk(1'b0, 32'h0000_0010, 2'b10, 1'b0, 32'h0,         32'hDEAD_BEEF, 1'b0, 3, 0, 4'b0,    32'h0,         13'd4);
        vecs[18] = mk(1'b0, 32'h0000_0000, 2'b10, 1'b0, 32'h0,         32'h0,        1'b0, 3, 0, 4'b0,    32'h0,         13'd0);
        vecs[19] = mk(1'b1, 32'h0000_0040, 2'b10, 1'b0, 32'h1111_1111, 32'h0,        1'b0, 2, 1, 4'b1111, 32'h1111_1111, 13'd16);

        // reset
        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_size = '0;
        req_unsigned = 1'b0; req_wdata = '0; rsp_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_rsp_valid", 32'(rsp_valid), 32'h0);
        check("reset_rsp_rdata", rsp_rdata, 32'h0);
        check("reset_rsp_err", 32'(rsp_err), 32'h0);
        check("reset_ram_wr_en", 32'(ram_wr_en), 32'h0);
        check("reset_ram_addr", 32'(ram_addr), 32'h0);
        check("reset_ram_be", 32'(ram_wr_byte_en), 32'h0);
        check("reset_ram_wdata", ram_wr_data, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);
        check("reset_req_ready", 32'(req_ready), 32'h1);

        // vector table
        for (int i = 0; i < 20; i++) begin
            exp_q.push_back(vecs[i].exp_rdata);
            do_req(vecs[i], rd, er, lat, pulses, be, wd, ra);
            exp_rd = exp_q.pop_front();
            tag = $sformatf("v%0d", i);
            check({tag, "_rdata"}, rd, exp_rd);
            check({tag, "_err"}, 32'(er), 32'(vecs[i].exp_err));
            check({tag, "_latency"}, 32'(lat), 32'(vecs[i].exp_lat));
            check({tag, "_wr_pulses"}, 32'(pulses), 32'(vecs[i].exp_pulses));
            if (!vecs[i].exp_err) check({tag, "_ram_addr"}, 32'(ra), 32'(vecs[i].exp_ra));
            if (vecs[i].exp_pulses != 0) begin
                check({tag, "_be"}, 32'(be), 32'(vecs[i].exp_be));
                check({tag, "_wr_data"}, wd, vecs[i].exp_wd);
            end
        end

        // backpressure: hold response for 5 cycles while a second request waits
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h10; req_size = 2'b10; req_unsigned = 1'b0;
        @(posedge clk);
        #1 req_addr = 32'h20;
        begin
            int n;
            n = 0;
            @(negedge clk);
            while (!rsp_valid && n < 20) begin
                @(negedge clk);
                n++;
            end
        end
        for (int c = 0; c < 5; c++) begin
            check("hold_rsp_valid", 32'(rsp_valid), 32'h1);
            check("hold_rsp_rdata", rsp_rdata, 32'hDEAD_BEEF);
            check("hold_req_ready", 32'(req_ready), 32'h0);
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check("release_req_ready", 32'(req_ready), 32'h1);
        check("release_rsp_valid", 32'(rsp_valid), 32'h0);
        @(negedge clk);
        check("next_accepted", 32'(req_ready), 32'h0);
        req_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("next_rsp_valid", 32'(rsp_valid), 32'h1);
        check("next_rsp_rdata", rsp_rdata, 32'h1234_5A00);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;

        // reset cuts a store during ACCESS
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h40; req_size = 2'b10; req_wdata = 32'hCAFE_F00D;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        check("cut_wr_en_before", 32'(ram_wr_en), 32'h1);
        rst_n = 1'b0;
        #1;
        check("cut_wr_en_after", 32'(ram_wr_en), 32'h0);
        check("cut_ram_addr", 32'(ram_addr), 32'h0);
        check("cut_ram_wdata", ram_wr_data, 32'h0);
        check("cut_ram_be", 32'(ram_wr_byte_en), 32'h0);
        check("cut_rsp_valid", 32'(rsp_valid), 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("cut_req_ready", 32'(req_ready), 32'h1);
        check("cut_rsp_valid_idle", 32'(rsp_valid), 32'h0);
        do_req(mk(1'b0, 32'h40, 2'b10, 1'b0, 32'h0, 32'h1111_1111, 1'b0, 3, 0, 4'b0, 32'h0, 13'd16),
               rd, er, lat, pulses, be, wd, ra);
        check("cut_reload_rdata", rd, 32'h1111_1111);
        check("cut_reload_latency", 32'(lat), 32'd3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
